uart_tx_arbiter: RTL

- Round-robin arbiter and sequencer sharing the single UART transmit module among NUM_REQ requesters.
- Latches the winner's 9-bit word, Parity and Speed, then issues a one-cycle start pulse to the transmitter.
- The transmitter has no busy output, so the arbiter times the frame itself from Speed and Parity.
- Sits between client logic and the transmitter's Start/Data/Parity/Speed inputs.

---
 rtl/uart_tx_arb_pkg.sv | 26 ++
 rtl/uart_tx_rr_picker.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: state encoding,
// frame geometry and the frame-length helper.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int FRAME_BITS_PAR   = 12;
    localparam int FRAME_BITS_NOPAR = 11;
    localparam int SPEED_ZERO_BP    = 16;
    localparam int CNT_W            = 8;

    // Frame length minus one; the counter hits zero on the last frame cycle.
    function automatic logic [CNT_W-1:0] frame_count(input logic       parity,
                                                     input logic [3:0] speed);
        int bp;
        int fb;
        bp = (speed == 4'd0) ? SPEED_ZERO_BP : int'(speed);
        fb = parity ? FRAME_BITS_PAR : FRAME_BITS_NOPAR;
        return CNT_W'(fb * bp - 1);
    endfunction

endpackage

// File: rtl/uart_tx_rr_picker.sv
// Round-robin picker: returns the first set request searching upward from
// ptr_i+1 with wrap-around.
module uart_tx_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic               valid_o,
    output logic [2:0]         idx_o
);

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        int c;
        valid_o = 1'b0;
        idx_o   = 3'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[c]) begin
                valid_o = 1'b1;
                idx_o   = 3'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; times each frame itself.
// Optional macro UART_TX_ARB_PRIORITY_EN gives requester 0 fixed priority.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 9,
    parameter int GAP_CYCLES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    input  logic                      parity_i,
    input  logic [3:0]                speed_i,
    output logic                      tx_start_o,
    output logic [DATA_W-1:0]         tx_data_o,
    output logic                      tx_parity_o,
    output logic [3:0]                tx_speed_o,
    output logic                      busy_o,
    output logic [2:0]                grant_id_o
);

    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GAP_W    = (GAP_LOAD > 0) ? $clog2(GAP_LOAD + 1) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          grant_q, grant_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_parity_q, tx_parity_d;
    logic [3:0]          tx_speed_q, tx_speed_d;
    logic                tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;

    logic [NUM_REQ-1:0]  pick_req;
    logic                pick_valid;
    logic [2:0]          pick_idx;
    logic                win_valid;
    logic [2:0]          win_idx;
    logic                move_ptr;

`ifdef UART_TX_ARB_PRIORITY_EN
    assign pick_req = req_i & ~NUM_REQ'(1);
`else
    assign pick_req = req_i;
`endif

    uart_tx_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (pick_req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // A fixed-priority grant to requester 0 leaves the rotation untouched.
    always_comb begin
        win_valid = pick_valid;
        win_idx   = pick_idx;
        move_ptr  = 1'b1;
`ifdef UART_TX_ARB_PRIORITY_EN
        if (req_i[0]) begin
            win_valid = 1'b1;
            win_idx   = 3'd0;
            move_ptr  = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        tx_parity_d = tx_parity_q;
        tx_speed_d  = tx_speed_q;
        tx_start_d  = 1'b0;
        ack_d       = '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    tx_data_d   = req_data_i[int'(win_idx)*DATA_W +: DATA_W];
                    tx_parity_d = parity_i;
                    tx_speed_d  = speed_i;
                    tx_start_d  = 1'b1;
                    ack_d       = NUM_REQ'(1) << win_idx;
                    grant_d     = win_idx;
                    if (move_ptr) begin
                        ptr_d = win_idx;
                    end
                    cnt_d   = frame_count(parity_i, speed_i);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_W'(GAP_LOAD);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            ptr_q       <= 3'(NUM_REQ - 1);
            grant_q     <= 3'd0;
            tx_data_q   <= '0;
            tx_parity_q <= 1'b0;
            tx_speed_q  <= 4'd0;
            tx_start_q  <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            tx_data_q   <= tx_data_d;
            tx_parity_q <= tx_parity_d;
            tx_speed_q  <= tx_speed_d;
            tx_start_q  <= tx_start_d;
            ack_q       <= ack_d;
        end
    end

    assign ack_o       = ack_q;
    assign tx_start_o  = tx_start_q;
    assign tx_data_o   = tx_data_q;
    assign tx_parity_o = tx_parity_q;
    assign tx_speed_o  = tx_speed_q;
    assign busy_o      = (state_q != IDLE);
    assign grant_id_o  = grant_q;

endmodule
